// File: rtl/bird_sprite_engine.sv
// Clears, moves and redraws a single bird sprite once per requested frame.
// Define BIRD_BOUNCE_EN to make a live bird reflect off screen edges instead of stopping at them.
module bird_sprite_engine #(
    parameter int unsigned SPRITE_W = 4,
    parameter int unsigned SPRITE_H = 4,
    parameter int unsigned SCR_W    = 160,
    parameter int unsigned SCR_H    = 120,
    parameter int unsigned SPEED    = 1,
    parameter int unsigned SPAWN_X  = 78,
    parameter int unsigned SPAWN_Y  = 58
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dir_load,
    input  logic [1:0] dir_in,
    input  logic       escape,
    input  logic       respawn,
    input  logic [7:0] spawn_x,
    input  logic [6:0] spawn_y,
    input  logic [7:0] Xplayer,
    input  logic [6:0] Yplayer,
    input  logic       firing,
    output logic [7:0] Xout,
    output logic [6:0] Yout,
    output logic [2:0] Colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       shot,
    output logic       flying,
    output logic       gone
);

    localparam logic [8:0] MaxX   = 9'(SCR_W - SPRITE_W);
    localparam logic [7:0] MaxY   = 8'(SCR_H - SPRITE_H);
    localparam logic [8:0] StepX  = 9'(SPEED);
    localparam logic [7:0] StepY  = 8'(SPEED);
    localparam logic [8:0] SpanX  = 9'(SPRITE_W - 1);
    localparam logic [7:0] SpanY  = 8'(SPRITE_H - 1);
    localparam logic [7:0] LastPx = 8'(SPRITE_W - 1);
    localparam logic [6:0] LastPy = 7'(SPRITE_H - 1);

    typedef enum logic [2:0] {StIdle, StClear, StMove, StDraw, StDone} frame_e;
    typedef enum logic [1:0] {BirdAlive, BirdFalling, BirdEscaping, BirdGone} bird_e;

    frame_e     frame_q, frame_d;
    bird_e      bird_q, bird_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [1:0] dir_q, dir_d;
    logic [7:0] px_q, px_d;
    logic [6:0] py_q, py_d;
    logic       fire_q, fire_d;
    logic       esc_q, esc_d;
    logic [7:0] xp_q, xp_d;
    logic [6:0] yp_q, yp_d;

    // One bit wider than each axis so steps past 0 or the limit never wrap.
    logic [8:0] x_w, xp_w;
    logic [7:0] y_w, yp_w;
    logic [7:0] step_x;
    logic [6:0] step_y;
    logic [1:0] step_dir;
    logic [6:0] fall_y, esc_y;
    logic       fall_end, esc_end, hit;
    logic       scan_last;

    always_comb begin
        x_w      = {1'b0, x_q};
        y_w      = {1'b0, y_q};
        xp_w     = {1'b0, xp_q};
        yp_w     = {1'b0, yp_q};
        step_x   = x_q;
        step_y   = y_q;
        step_dir = dir_q;

        if (dir_q[0]) begin
            if (x_w + StepX > MaxX) begin
`ifdef BIRD_BOUNCE_EN
                step_dir[0] = 1'b0;
                step_x      = (x_w >= StepX) ? 8'(x_w - StepX) : 8'd0;
`else
                step_x      = 8'(MaxX);
`endif
            end else begin
                step_x = 8'(x_w + StepX);
            end
        end else begin
            if (x_w < StepX) begin
`ifdef BIRD_BOUNCE_EN
                step_dir[0] = 1'b1;
                step_x      = (x_w + StepX > MaxX) ? 8'(MaxX) : 8'(x_w + StepX);
`else
                step_x      = 8'd0;
`endif
            end else begin
                step_x = 8'(x_w - StepX);
            end
        end

        if (dir_q[1]) begin
            if (y_w + StepY > MaxY) begin
`ifdef BIRD_BOUNCE_EN
                step_dir[1] = 1'b0;
                step_y      = (y_w >= StepY) ? 7'(y_w - StepY) : 7'd0;
`else
                step_y      = 7'(MaxY);
`endif
            end else begin
                step_y = 7'(y_w + StepY);
            end
        end else begin
            if (y_w < StepY) begin
`ifdef BIRD_BOUNCE_EN
                step_dir[1] = 1'b1;
                step_y      = (y_w + StepY > MaxY) ? 7'(MaxY) : 7'(y_w + StepY);
`else
                step_y      = 7'd0;
`endif
            end else begin
                step_y = 7'(y_w - StepY);
            end
        end

        fall_end = (y_w + StepY >= MaxY);
        fall_y   = fall_end ? 7'(MaxY) : 7'(y_w + StepY);
        esc_end  = (y_w <= StepY);
        esc_y    = esc_end ? 7'd0 : 7'(y_w - StepY);

        hit = fire_q && (bird_q == BirdAlive) &&
              (xp_w >= x_w) && (xp_w <= x_w + SpanX) &&
              (yp_w >= y_w) && (yp_w <= y_w + SpanY);
    end

    assign scan_last = (px_q == LastPx) && (py_q == LastPy);

    always_comb begin
        frame_d = frame_q;
        bird_d  = bird_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        px_d    = px_q;
        py_d    = py_q;
        fire_d  = fire_q;
        esc_d   = esc_q;
        xp_d    = xp_q;
        yp_d    = yp_q;

        unique case (frame_q)
            StIdle: begin
                // Respawn wins over a simultaneous start, which is dropped.
                if (respawn) begin
                    x_d    = spawn_x;
                    y_d    = spawn_y;
                    bird_d = BirdAlive;
                end else if (start) begin
                    frame_d = StClear;
                    px_d    = '0;
                    py_d    = '0;
                    fire_d  = firing;
                    esc_d   = escape;
                    xp_d    = Xplayer;
                    yp_d    = Yplayer;
                    if (dir_load) begin
                        dir_d = dir_in;
                    end
                end
            end
            StClear, StDraw: begin
                if (scan_last) begin
                    px_d    = '0;
                    py_d    = '0;
                    frame_d = (frame_q == StClear) ? StMove : StDone;
                end else if (px_q == LastPx) begin
                    px_d = '0;
                    py_d = py_q + 7'd1;
                end else begin
                    px_d = px_q + 8'd1;
                end
            end
            StMove: begin
                unique case (bird_q)
                    BirdAlive: begin
                        if (hit) begin
                            bird_d = BirdFalling;
                        end else if (esc_q) begin
                            y_d    = esc_y;
                            bird_d = esc_end ? BirdGone : BirdEscaping;
                        end else begin
                            x_d   = step_x;
                            y_d   = step_y;
                            dir_d = step_dir;
                        end
                    end
                    BirdFalling: begin
                        y_d = fall_y;
                        if (fall_end) begin
                            bird_d = BirdGone;
                        end
                    end
                    BirdEscaping: begin
                        y_d = esc_y;
                        if (esc_end) begin
                            bird_d = BirdGone;
                        end
                    end
                    default: ;
                endcase
                frame_d = (bird_d == BirdGone) ? StDone : StDraw;
            end
            StDone:  frame_d = StIdle;
            default: frame_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= StIdle;
            bird_q  <= BirdAlive;
            x_q     <= 8'(SPAWN_X);
            y_q     <= 7'(SPAWN_Y);
            dir_q   <= 2'b01;
            px_q    <= '0;
            py_q    <= '0;
            fire_q  <= 1'b0;
            esc_q   <= 1'b0;
            xp_q    <= '0;
            yp_q    <= '0;
        end else begin
            frame_q <= frame_d;
            bird_q  <= bird_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            px_q    <= px_d;
            py_q    <= py_d;
            fire_q  <= fire_d;
            esc_q   <= esc_d;
            xp_q    <= xp_d;
            yp_q    <= yp_d;
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    always_comb begin
        plot   = (frame_q == StClear) || (frame_q == StDraw);
        Xout   = '0;
        Yout   = '0;
        Colour = 3'b000;
        if (plot) begin
            Xout = x_q + px_q;
            Yout = y_q + py_q;
        end
        if (frame_q == StDraw) begin
            Colour = (bird_q == BirdFalling) ? 3'b100 : 3'b111;
        end
        busy   = (frame_q != StIdle);
        done   = (frame_q == StDone);
        shot   = (bird_q == BirdFalling);
        flying = (bird_q == BirdFalling) || (bird_q == BirdEscaping);
        gone   = (bird_q == BirdGone);
    end

endmodule

// File: doc/bird_sprite_engine.md
BIRD_SPRITE_ENGINE -- requirements
Module: bird_sprite_engine

Interface
REQ-001 SHALL have parameter SPRITE_W, default 4: sprite width in pixels.
REQ-002 SHALL have parameter SPRITE_H, default 4: sprite height in pixels.
REQ-003 SHALL have parameters SCR_W and SCR_H, defaults 160 and 120: screen size in pixels.
REQ-004 SHALL have parameter SPEED, default 1: pixels moved per frame on each axis.
REQ-005 SHALL have parameters SPAWN_X and SPAWN_Y, defaults 78 and 58: position after reset.
REQ-006 SHALL have ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled in IDLE only.
- dir_load  in  1  when high with accepted start, load dir_in.
- dir_in  in  2  bit0=1 right / 0 left; bit1=1 down / 0 up.
- escape  in  1  ALIVE to ESCAPING request, sampled with accepted start.
- respawn  in  1  in IDLE, load spawn_x/spawn_y and set ALIVE.
- spawn_x / spawn_y  in  8 / 7  respawn position.
- Xplayer / Yplayer  in  8 / 7  crosshair position.
- firing  in  1  trigger, sampled with accepted start.
- Xout / Yout  out  8 / 7  pixel coordinate.
- Colour  out  3  pixel colour.
- plot  out  1  pixel valid.
- busy  out  1  high whenever FSM is not IDLE.
- done  out  1  one-cycle frame-complete pulse.
- shot  out  1  high while bird is FALLING.
- flying  out  1  high while bird is FALLING or ESCAPING.
- gone  out  1  high while bird is GONE.

Function
REQ-007 Frame FSM SHALL have states IDLE -> CLEAR -> MOVE -> DRAW -> DONE -> IDLE; start in IDLE is accepted; start in any other state is ignored.
REQ-008 Bird FSM SHALL have states ALIVE, FALLING, ESCAPING, GONE; it changes only in MOVE, or through respawn.
REQ-009 CLEAR and DRAW SHALL each last exactly SPRITE_W*SPRITE_H cycles. Each cycle emits plot=1, Xout=posX+px, Yout=posY+py. Scan is row-major, px fastest, starting at (0,0).
REQ-010 Colour SHALL be 000 in CLEAR; in DRAW: 111 for ALIVE or ESCAPING, 100 for FALLING.
REQ-011 In GONE, DRAW SHALL be skipped (MOVE -> DONE) and plot stays low.
REQ-012 In MOVE, plot=0 and the position updates once:
- ALIVE: x +/- SPEED, y +/- SPEED per direction.
- FALLING: y + SPEED; at y >= SCR_H-SPRITE_H, clamp and go GONE.
- ESCAPING: y - SPEED saturating at 0; at 0, go GONE.
REQ-013 ALIVE movement SHALL keep x in [0, SCR_W-SPRITE_W] and y in [0, SCR_H-SPRITE_H]; edge handling is set by BOUNCE_EN.
REQ-014 Hit SHALL be evaluated in MOVE, on the pre-move position, if the bird is ALIVE and firing was latched:
- Condition: posX <= Xplayer <= posX+SPRITE_W-1 and posY <= Yplayer <= posY+SPRITE_H-1.
- On hit: go FALLING; the position does not move this frame.
REQ-015 When hit and escape are both latched in the same frame, hit SHALL win.
REQ-016 done SHALL be high for exactly the one cycle spent in DONE.
REQ-017 Frame latency SHALL be 2*SPRITE_W*SPRITE_H+2 cycles after the start cycle, or SPRITE_W*SPRITE_H+2 when GONE.
REQ-018 respawn SHALL act only in IDLE and SHALL take priority over a start in the same cycle; that start is dropped.
REQ-019 Intermediate arithmetic SHALL be one bit wider than the axis width, so no wrap-around occurs at 0 or at the screen limit.

Reset
REQ-020 Reset SHALL set:
- Frame FSM to IDLE and bird FSM to ALIVE.
- Position to (SPAWN_X, SPAWN_Y) and dir to 2'b01 (right, up).
- Scan counters to 0.
- Xout, Yout, Colour, plot, busy, done, shot, flying and gone to 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately; plot falls in the same cycle as reset, and no done pulse is issued.

Configuration
REQ-022 Macro BIRD_BOUNCE_EN SHALL select ALIVE edge handling.
- Defined: a step that would leave the range reflects. The relevant dir bit inverts, and the bird moves SPEED in the new direction that frame.
- Undefined: the coordinate saturates at the limit and dir is unchanged.

Verification
REQ-023 Scenario: reset, start -> plot high 16 cycles with Colour 000 from (78,58), 1 idle cycle, 16 cycles Colour 111 from (79,57), then done one cycle 34 cycles after start.
REQ-024 Scenario: firing=1, Xplayer=81, Yplayer=61 at (78,58), start -> shot=1, flying=1, DRAW Colour 100 at (78,58); later frames move y+1 each frame until y=116, then gone=1 and the next frame has no DRAW.
REQ-025 Scenario: Xplayer=82 (outside) with firing=1 -> shot stays 0 and the bird moves to (79,57).
REQ-026 Scenario: respawn at (156,10), dir_load with dir=01, start -> with BIRD_BOUNCE_EN draws at (155,9) and dir bit0=0; without it draws at (156,9).
REQ-027 Scenario: escape=1 at y=1, start -> ESCAPING, y=0, gone=1; next start gives done 18 cycles later.
REQ-028 Scenario: reset mid-DRAW, then start asserted during busy -> plot and busy drop at once, the busy-cycle start is ignored, position returns to (78,58).
